// File: rtl/imm_encoder.sv
// Packs a signed immediate into RISC-V I/S/B/U/J fields of a base word and queues the result
// with a sequential I-mem address. Define IMM_RANGE_CHECK_EN to enable immediate range checks.
module imm_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ERR_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_fmt,
  input  logic [31:0]              in_base,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_addr,
  output logic                     out_err,
  output logic [ERR_W-1:0]         err_cnt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [31:0]     inst_q [DEPTH];
  logic [31:0]     addr_q [DEPTH];
  logic            err_q  [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [31:0]     next_addr_q;

  logic        push, pop;
  logic [31:0] mask, packed_imm, enc, wr_inst;
  logic        wr_err;

  assign in_ready  = (count_q < Full);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  assign out_inst = out_valid ? inst_q[rd_ptr_q] : '0;
  assign out_addr = out_valid ? addr_q[rd_ptr_q] : '0;
  assign out_err  = out_valid ? err_q[rd_ptr_q]  : 1'b0;

  always_comb begin
    mask       = '0;
    packed_imm = '0;
    case (in_fmt)
      3'd0: begin
        mask       = 32'hFFF0_0000;
        packed_imm = {in_imm[11:0], 20'b0};
      end
      3'd1: begin
        mask       = 32'hFE00_0F80;
        packed_imm = {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0};
      end
      3'd2: begin
        mask       = 32'hFE00_0F80;
        packed_imm = {in_imm[12], in_imm[10:5], 13'b0, in_imm[4:1], in_imm[11], 7'b0};
      end
      3'd3: begin
        mask       = 32'hFFFF_F000;
        packed_imm = {in_imm[31:12], 12'b0};
      end
      3'd4: begin
        mask       = 32'hFFFF_F000;
        packed_imm = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'b0};
      end
      default: ;
    endcase
    enc = (in_base & ~mask) | packed_imm;
  end

`ifdef IMM_RANGE_CHECK_EN
  logic             bad;
  logic [ERR_W-1:0] err_cnt_q;

  // A signed value fits in N bits when all bits from N-1 upward are equal.
  always_comb begin
    bad = 1'b0;
    case (in_fmt)
      3'd0, 3'd1: bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      3'd2:       bad = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      3'd3:       bad = (in_imm[11:0] != 12'h000);
      3'd4:       bad = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      default:    bad = 1'b1;
    endcase
  end

  assign wr_err  = bad;
  assign wr_inst = bad ? in_base : enc;
  assign err_cnt = err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (push && bad && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end
`else
  logic unused_imm;
  assign unused_imm = in_imm[0];
  assign wr_err     = 1'b0;
  assign wr_inst    = enc;
  assign err_cnt    = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      next_addr_q <= BASE_ADDR;
    end else begin
      if (push) begin
        inst_q[wr_ptr_q] <= wr_inst;
        addr_q[wr_ptr_q] <= next_addr_q;
        err_q[wr_ptr_q]  <= wr_err;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
        next_addr_q      <= next_addr_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder; checks both builds depending on IMM_RANGE_CHECK_EN.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_fmt;
  logic [31:0] in_base, in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_addr;
  logic        out_err;
  logic [7:0]  err_cnt;
  logic [2:0]  count;

  int n_total = 0;
  int n_pass  = 0;

  imm_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000), .ERR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_base   (in_base),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .err_cnt   (err_cnt),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic [2:0] f, input logic [31:0] b, input logic [31:0] i);
    in_valid = 1'b1;
    in_fmt   = f;
    in_base  = b;
    in_imm   = i;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    in_fmt  = 3'd0;
    in_base = '0;
    in_imm  = '0;
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Single-entry encodes, popped one at a time
    out_ready = 1'b1;
    push(3'd0, 32'h0000_2083, 32'hFFFF_FFFC);
    chk("i_valid", 32'(out_valid), 32'd1);
    chk("i_inst", out_inst, 32'hFFC0_2083);
    chk("i_addr", out_addr, 32'd0);
    chk("i_err", 32'(out_err), 32'd0);
    step();
    chk("i_popped", 32'(count), 32'd0);
    push(3'd2, 32'h0000_0063, 32'hFFFF_FFF8);
    chk("b_inst", out_inst, 32'hFE00_0CE3);
    chk("b_addr", out_addr, 32'd4);
    step();
    push(3'd4, 32'h0000_006F, 32'd2048);
    chk("j_inst", out_inst, 32'h0010_006F);
    chk("j_addr", out_addr, 32'd8);
    step();
    push(3'd1, 32'h0000_2023, 32'hFFFF_FFFC);
    chk("s_inst", out_inst, 32'hFE00_2E23);
    step();
    push(3'd3, 32'h0000_0037, 32'h1234_5000);
    chk("u_inst", out_inst, 32'h1234_5037);
    step();
    push(3'd4, 32'h0000_006F, 32'hFFF0_0000);
    chk("j_min_inst", out_inst, 32'h8000_006F);
    chk("j_min_err", 32'(out_err), 32'd0);
    step();
    chk("empty_ignores_ready", 32'(count), 32'd0);

    // Backpressure: fill with out_ready low
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("fill_in_ready", 32'(in_ready), 32'd1);
      push(3'd0, 32'h0000_0013, 32'(i));
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_imm   = 32'd4;
    step();
    chk("full_no_accept", 32'(count), 32'd4);
    out_ready = 1'b1;
    chk("full_pop_in_ready", 32'(in_ready), 32'd0);
    chk("head0_addr", out_addr, 32'd0);
    chk("head0_inst", out_inst, 32'h0000_0013);
    step();
    in_valid = 1'b0;
    chk("no_bypass_count", 32'(count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      chk("pop_addr", out_addr, 32'(4 * i));
      chk("pop_inst", out_inst, 32'h0000_0013 | (32'(i) << 20));
      step();
    end
    chk("drained", 32'(count), 32'd0);

    // Simultaneous push/pop at count=2
    out_ready = 1'b0;
    push(3'd0, 32'h0000_0013, 32'd0);
    push(3'd0, 32'h0000_0013, 32'd0);
    chk("two_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    push(3'd0, 32'h0000_0013, 32'd0);
    chk("pushpop_count", 32'(count), 32'd2);
    chk("pushpop_head", out_addr, 32'd20);
    step();
    chk("pushpop_tail", out_addr, 32'd24);
    step();
    chk("pushpop_drained", 32'(count), 32'd0);

    // Range checks
    do_reset();
`ifdef IMM_RANGE_CHECK_EN
    push(3'd0, 32'h0000_0013, 32'd2048);
    push(3'd2, 32'h0000_0063, 32'd3);
    push(3'd6, 32'h0000_0033, 32'd0);
    chk("err_cnt3", 32'(err_cnt), 32'd3);
    out_ready = 1'b1;
    chk("bad_i_err", 32'(out_err), 32'd1);
    chk("bad_i_inst", out_inst, 32'h0000_0013);
    step();
    chk("bad_b_err", 32'(out_err), 32'd1);
    chk("bad_b_inst", out_inst, 32'h0000_0063);
    chk("bad_b_addr", out_addr, 32'd4);
    step();
    chk("bad_f_err", 32'(out_err), 32'd1);
    chk("bad_f_inst", out_inst, 32'h0000_0033);
    step();
    out_ready = 1'b0;
`else
    out_ready = 1'b1;
    push(3'd0, 32'h0000_0013, 32'd2048);
    chk("trunc_inst", out_inst, 32'h8000_0013);
    chk("trunc_err", 32'(out_err), 32'd0);
    chk("trunc_err_cnt", 32'(err_cnt), 32'd0);
    push(3'd6, 32'h0000_0033, 32'hFFFF_FFFF);
    chk("illegal_pass", out_inst, 32'h0000_0033);
    step();
    out_ready = 1'b0;
`endif

    // Reset mid-stream with 3 queued
    push(3'd1, 32'h0000_2023, 32'd8);
    push(3'd1, 32'h0000_2023, 32'd12);
    push(3'd5, 32'h0000_2023, 32'd16);
    chk("pre_rst_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    step();
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_inst", out_inst, 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    push(3'd0, 32'h0000_2083, 32'd1);
    chk("post_rst_addr", out_addr, 32'd0);
    chk("post_rst_inst", out_inst, 32'h0010_2083);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the core's immediate decode path: packs a signed 32-bit immediate into the RISC-V I/S/B/U/J bit positions of a base instruction word.
- Sits between the test/boot loader and instruction memory. Accepts {format, base word, immediate} over valid/ready, range-checks the immediate, and buffers encoded words in a small FIFO.
- Each word is tagged with a sequential I-mem byte address.

Parameters:
- DEPTH, 4, output FIFO entries (power of 2, >=2)
- BASE_ADDR, 32'h0000_0000, address given to first accepted instruction after reset
- ERR_W, 8, width of saturating error counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept this cycle
- in_fmt  in  3  0=I, 1=S, 2=B, 3=U, 4=J, 5-7 illegal
- in_base  in  32  instruction with opcode/rd/rs1/rs2/funct fields set; immediate bits don't-care
- in_imm  in  32  signed immediate (U: full value, low 12 bits expected 0)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head
- out_inst  out  32  encoded instruction
- out_addr  out  32  I-mem byte address of out_inst
- out_err  out  1  head entry failed range/alignment/format check
- err_cnt  out  ERR_W  saturating count of rejected requests
- count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset is rst_n: synchronous, active-low, sampled on the rising clk edge. It clears the FIFO (count=0, out_valid=0), sets the address counter to BASE_ADDR, and sets err_cnt=0. out_inst, out_addr and out_err read 0 while the FIFO is empty. Reset mid-stream discards all buffered entries; no partial output.
- Handshake:
  - Accept when in_valid && in_ready, where in_ready = (count < DEPTH).
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle are legal when 0 < count < DEPTH; count is unchanged.
  - When count == DEPTH, in_ready = 0 even if a pop occurs that cycle (no full-bypass).
  - When count == 0, out_valid = 0, no combinational bypass, and out_ready is ignored.
- Latency: an accepted request appears at the FIFO head on the next cycle when the FIFO was empty. Otherwise it appears in order behind earlier entries.
- Encoding: immediate field bits of in_base are cleared, then the packed immediate is ORed in. All other bits pass through unchanged.
  - I: imm[11:0] -> [31:20]
  - S: imm[11:5] -> [31:25], imm[4:0] -> [11:7]
  - B: imm[12] -> 31, imm[10:5] -> [30:25], imm[4:1] -> [11:8], imm[11] -> 7
  - U: imm[31:12] -> [31:12]
  - J: imm[20] -> 31, imm[10:1] -> [30:21], imm[11] -> 20, imm[19:12] -> [19:12]
- Checks, computed at accept time:
  - I/S: -2048..2047
  - B: -4096..4094 and imm[0]=0
  - J: -1048576..1048574 and imm[0]=0
  - U: imm[11:0]=0
  - fmt 5-7: always error
- Address: each accepted request (good or bad) is stamped with the current address counter, then the counter increments by 4. It wraps modulo 2^32 with no flag.
- err_cnt increments on each accepted erroneous request and saturates at all-ones.

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- Defined: a failing request is still accepted and still consumes an address. It is written to the FIFO with out_inst = in_base unchanged and out_err=1, and err_cnt increments.
- Undefined: no checks. The immediate is silently truncated to the format's bits (fmt 5-7 pass in_base through). out_err is tied 0 and err_cnt is tied 0.

Test Plan:
- Reset, then I-type with in_base=32'h0000_2083 (lw x1,0(x0)) and imm=-4 -> next cycle out_inst=32'hFFC0_2083, out_addr=0, out_err=0.
- B-type with in_base=32'h0000_0063 and imm=-8 -> out_inst=32'hFE00_0CE3. J-type with in_base=32'h0000_006F and imm=2048 -> 32'h0010_006F.
- Backpressure: hold out_ready=0 and push DEPTH+1 requests -> in_ready falls after DEPTH accepts and count=DEPTH. Then pulse out_ready -> entries pop in order with addresses 0, 4, 8, 12.
- Simultaneous push/pop at count=2 -> count stays 2. Push at count=DEPTH with out_ready=1 -> not accepted that cycle.
- With IMM_RANGE_CHECK_EN: I-type imm=2048, B-type imm=3, fmt=6 -> three entries with out_err=1, out_inst=in_base, err_cnt=3. Without the macro: the same I-type request gives bits [31:20]=12'h800 and out_err=0.
- Assert rst_n=0 with 3 entries queued -> next cycle count=0, out_valid=0, next accepted address=BASE_ADDR, err_cnt=0.
